// File: rtl/dma_csr_pkg.sv
// dma_csr_pkg: response codes, register map offsets and FSM encodings for the DMA CSR slave
package dma_csr_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [7:0] CTRL       = 8'h00;
  localparam logic [7:0] STATUS     = 8'h04;
  localparam logic [7:0] IRQ_MASK   = 8'h08;
  localparam logic [7:0] SRC_ADDR   = 8'h0C;
  localparam logic [7:0] DST_ADDR   = 8'h10;
  localparam logic [7:0] XFER_LEN   = 8'h14;
  localparam logic [7:0] IRQ_STATUS = 8'h18;
  localparam logic [7:0] VERSION    = 8'h1C;
  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;
endpackage

// File: rtl/dma_csr_rd_mux.sv
// dma_csr_rd_mux: selects one register word from the flattened readback bus, flagging bad addresses
module dma_csr_rd_mux
  import dma_csr_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int NREG   = 8
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic [NREG*DATA_W-1:0] reg_rd_data,
  output logic [DATA_W-1:0]      data,
  output logic                   err
);
  logic [ADDR_W-3:0] idx;
  assign idx = addr[ADDR_W-1:2];
  assign err = addr[1:0] != 2'b00 || int'(idx) >= NREG;
  always_comb begin
    data = '0;
    for (int k = 0; k < NREG; k++)
      data = !err && int'(idx) == k ? reg_rd_data[k*DATA_W +: DATA_W] : data;
  end
endmodule

// File: rtl/dma_csr_axil_slave.sv
// dma_csr_axil_slave: AXI4-Lite front-end issuing one-cycle byte-merged register writes and registered reads
module dma_csr_axil_slave
  import dma_csr_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int NREG   = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [ADDR_W-1:0]      s_awaddr,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  input  logic [DATA_W-1:0]      s_wdata,
  input  logic [DATA_W/8-1:0]    s_wstrb,
  input  logic                   s_wvalid,
  output logic                   s_wready,
  output logic [1:0]             s_bresp,
  output logic                   s_bvalid,
  input  logic                   s_bready,
  input  logic [ADDR_W-1:0]      s_araddr,
  input  logic                   s_arvalid,
  output logic                   s_arready,
  output logic [DATA_W-1:0]      s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rvalid,
  input  logic                   s_rready,
  output logic [NREG-1:0]        reg_wr_en,
  output logic [DATA_W-1:0]      reg_wr_data,
  input  logic [NREG*DATA_W-1:0] reg_rd_data
);
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic live, aw_held, w_held, aw_hs, w_hs, ar_hs, wr_err, rd_err;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q, wr_old, rd_word;
  logic [DATA_W/8-1:0] wstrb_q;
  // live keeps every ready low during reset and for the first cycle after release
  assign s_awready = live && w_state == W_IDLE && !aw_held;
  assign s_wready  = live && w_state == W_IDLE && !w_held;
  assign s_arready = live && r_state == R_IDLE;
  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;
  assign ar_hs = s_arvalid && s_arready;
  dma_csr_rd_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREG(NREG)) u_wr_mux (
    .addr(awaddr_q), .reg_rd_data(reg_rd_data), .data(wr_old), .err(wr_err)
  );
  dma_csr_rd_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREG(NREG)) u_rd_mux (
    .addr(s_araddr), .reg_rd_data(reg_rd_data), .data(rd_word), .err(rd_err)
  );
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      live     <= 1'b0;
      w_state  <= W_IDLE;
      r_state  <= R_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      s_bresp  <= RESP_OKAY;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
    end else begin
      live    <= 1'b1;
      w_state <= w_next;
      r_state <= r_next;
      aw_held <= w_state == W_EXEC ? 1'b0 : aw_held || aw_hs;
      w_held  <= w_state == W_EXEC ? 1'b0 : w_held || w_hs;
      if (aw_hs) awaddr_q <= s_awaddr;
      if (w_hs) begin
        wdata_q <= s_wdata;
        wstrb_q <= s_wstrb;
      end
      if (w_state == W_EXEC) s_bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
      if (ar_hs) begin
        s_rdata <= rd_word;
        s_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end
  always_comb begin
    w_next = w_state == W_IDLE && (aw_held || aw_hs) && (w_held || w_hs) ? W_EXEC :
             w_state == W_EXEC ? W_RESP :
             w_state == W_RESP && s_bready ? W_IDLE : w_state;
    r_next = r_state == R_IDLE && ar_hs ? R_RESP :
             r_state == R_RESP && s_rready ? R_IDLE : r_state;
    s_bvalid  = w_state == W_RESP;
    s_rvalid  = r_state == R_RESP;
    reg_wr_en = w_state == W_EXEC && !wr_err ? NREG'(1) << awaddr_q[ADDR_W-1:2] : '0;
    reg_wr_data = '0;
    // unstrobed bytes keep the addressed register's current value
    for (int b = 0; b < DATA_W/8; b++)
      reg_wr_data[b*8 +: 8] = w_state != W_EXEC ? 8'h00 :
                              wstrb_q[b] ? wdata_q[b*8 +: 8] : wr_old[b*8 +: 8];
  end
endmodule

// File: tb/tb_dma_csr_axil_slave.sv
// tb_dma_csr_axil_slave: scenario tasks with a scoreboard of expected register writes, B and R responses
module tb_dma_csr_axil_slave;
  import dma_csr_pkg::*;
  localparam int NREG = 8;
  logic clk = 1'b0, resetn = 1'b1;
  logic [7:0] s_awaddr = '0, s_araddr = '0;
  logic s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0, s_arvalid = 1'b0, s_rready = 1'b0;
  logic [31:0] s_wdata = '0;
  logic [3:0] s_wstrb = '0;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0] s_bresp, s_rresp;
  logic [31:0] s_rdata, reg_wr_data;
  logic [NREG-1:0] reg_wr_en;
  logic [NREG*32-1:0] reg_rd_data;
  logic [31:0] regs [NREG];
  logic [39:0] wr_obs[$], wr_exp[$];
  logic [1:0] b_obs[$], b_exp[$];
  logic [33:0] r_obs[$], r_exp[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;
  always_comb begin
    reg_rd_data = '0;
    for (int k = 0; k < NREG; k++) reg_rd_data[k*32 +: 32] = regs[k];
  end

  dma_csr_axil_slave #(.ADDR_W(8), .DATA_W(32), .NREG(NREG)) dut (
    .clk(clk), .resetn(resetn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data)
  );

  // one clock: observe at negedge, let the register cells take any write after the edge
  task automatic cyc();
    logic [NREG-1:0] en;
    logic [31:0] d;
    @(negedge clk);
    en = reg_wr_en;
    d = reg_wr_data;
    if (en != 0) wr_obs.push_back({en, d});
    if (s_bvalid && s_bready) b_obs.push_back(s_bresp);
    if (s_rvalid && s_rready) r_obs.push_back({s_rdata, s_rresp});
    @(posedge clk);
    #1;
    for (int k = 0; k < NREG; k++) if (en[k]) regs[k] = d;
  endtask

  task automatic write_txn(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, output bit ok);
    bit aw_done = 0, w_done = 0;
    s_awaddr = a; s_wdata = d; s_wstrb = s; s_awvalid = 1; s_wvalid = 1;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      aw_done |= s_awvalid && s_awready;
      w_done |= s_wvalid && s_wready;
      cyc();
      s_awvalid = !aw_done;
      s_wvalid = !w_done;
    end
    ok = aw_done && w_done;
  endtask

  task automatic wait_b(input int hold, output int high, output bit ok);
    high = 0;
    s_bready = 0;
    for (int n = 0; n < 20 && !s_bvalid; n++) cyc();
    for (int i = 0; i < hold; i++) begin
      high += int'(s_bvalid);
      cyc();
    end
    s_bready = 1;
    ok = s_bvalid;
    cyc();
    s_bready = 0;
  endtask

  task automatic read_txn(input logic [7:0] a, input int hold, output int stable, output bit ok);
    logic [31:0] first;
    bit first_rv;
    stable = 0;
    s_araddr = a; s_arvalid = 1; s_rready = 0;
    for (int n = 0; n < 20 && !s_arready; n++) cyc();
    ok = s_arready;
    cyc();
    s_arvalid = 0;
    first_rv = s_rvalid;
    first = s_rdata;
    for (int i = 0; i < hold; i++) begin
      stable += int'(s_rvalid && s_rdata === first);
      cyc();
    end
    s_rready = 1;
    ok = ok && first_rv && s_rvalid;
    cyc();
    s_rready = 0;
  endtask

  task automatic test_reset();
    #2 resetn = 0;
    cyc(); cyc();
    checks++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake got %b expected 00000", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
    end
    checks++;
    if ({s_bresp, s_rresp, s_rdata, reg_wr_en, reg_wr_data} !== '0) begin
      errors++; $display("FAIL reset_data got bresp=%b rresp=%b rdata=%h en=%b wd=%h expected all zero", s_bresp, s_rresp, s_rdata, reg_wr_en, reg_wr_data);
    end
    resetn = 1;
    cyc(); cyc();
    checks++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) begin
      errors++; $display("FAIL reset_release_ready got %b expected 111", {s_awready, s_wready, s_arready});
    end
  endtask

  task automatic test_basic();
    s_awaddr = STATUS; s_wdata = 32'h0000_0003; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
    wr_exp.push_back({8'b0000_0010, 32'h0000_0003});
    b_exp.push_back(RESP_OKAY);
    cyc();
    s_awvalid = 0; s_wvalid = 0;
    checks++;
    if (reg_wr_en !== 8'b0000_0010 || reg_wr_data !== 32'h3 || s_bvalid !== 1'b0) begin
      errors++; $display("FAIL basic_exec got en=%b wd=%h bvalid=%b expected 00000010 00000003 0", reg_wr_en, reg_wr_data, s_bvalid);
    end
    cyc();
    checks++;
    if (reg_wr_en !== 8'b0 || s_bvalid !== 1'b1 || s_bresp !== RESP_OKAY) begin
      errors++; $display("FAIL basic_resp got en=%b bvalid=%b bresp=%b expected 00000000 1 00", reg_wr_en, s_bvalid, s_bresp);
    end
    s_bready = 1;
    cyc();
    s_bready = 0;
    checks++;
    if (wr_obs.size() != wr_exp.size() || b_obs.size() != b_exp.size()) begin
      errors++; $display("FAIL basic_count got wr=%0d b=%0d expected wr=%0d b=%0d", wr_obs.size(), b_obs.size(), wr_exp.size(), b_exp.size());
    end
    while (wr_obs.size() && wr_exp.size()) begin
      checks++;
      if (wr_obs[0] !== wr_exp[0]) begin errors++; $display("FAIL basic_wr got %h expected %h", wr_obs[0], wr_exp[0]); end
      void'(wr_obs.pop_front()); void'(wr_exp.pop_front());
    end
    while (b_obs.size() && b_exp.size()) begin
      checks++;
      if (b_obs[0] !== b_exp[0]) begin errors++; $display("FAIL basic_b got %b expected %b", b_obs[0], b_exp[0]); end
      void'(b_obs.pop_front()); void'(b_exp.pop_front());
    end
  endtask

  task automatic test_w_first();
    int high;
    bit ok;
    s_wdata = 32'h0000_00F0; s_wstrb = 4'hF; s_wvalid = 1;
    wr_exp.push_back({8'b0000_0100, 32'h0000_00F0});
    b_exp.push_back(RESP_OKAY);
    cyc();
    s_wvalid = 0;
    checks++;
    if (s_wready !== 1'b0 || s_awready !== 1'b1) begin
      errors++; $display("FAIL wfirst_ready got wready=%b awready=%b expected 0 1", s_wready, s_awready);
    end
    cyc(); cyc();
    s_awaddr = IRQ_MASK; s_awvalid = 1;
    cyc();
    s_awvalid = 0;
    checks++;
    if (s_awready !== 1'b0 || reg_wr_en !== 8'b0000_0100) begin
      errors++; $display("FAIL wfirst_exec got awready=%b en=%b expected 0 00000100", s_awready, reg_wr_en);
    end
    wait_b(5, high, ok);
    checks++;
    if (!ok || high != 5) begin errors++; $display("FAIL wfirst_bhold got bvalid_cycles=%0d ok=%b expected 5 1", high, ok); end
    checks++;
    if (wr_obs.size() != wr_exp.size()) begin
      errors++; $display("FAIL wfirst_wr_count got %0d expected %0d", wr_obs.size(), wr_exp.size());
    end
    while (wr_obs.size() && wr_exp.size()) begin
      checks++;
      if (wr_obs[0] !== wr_exp[0]) begin errors++; $display("FAIL wfirst_wr got %h expected %h", wr_obs[0], wr_exp[0]); end
      void'(wr_obs.pop_front()); void'(wr_exp.pop_front());
    end
    while (b_obs.size() && b_exp.size()) begin
      checks++;
      if (b_obs[0] !== b_exp[0]) begin errors++; $display("FAIL wfirst_b got %b expected %b", b_obs[0], b_exp[0]); end
      void'(b_obs.pop_front()); void'(b_exp.pop_front());
    end
  endtask

  task automatic test_partial();
    int high;
    bit ok;
    regs[0] = 32'hAABB_CCDD;
    wr_exp.push_back({8'b0000_0001, 32'hAA22_CC44});
    write_txn(CTRL, 32'h1122_3344, 4'b0101, ok);
    wait_b(0, high, ok);
    checks++;
    if (wr_obs.size() != wr_exp.size()) begin
      errors++; $display("FAIL partial_wr_count got %0d expected %0d", wr_obs.size(), wr_exp.size());
    end
    while (wr_obs.size() && wr_exp.size()) begin
      checks++;
      if (wr_obs[0] !== wr_exp[0]) begin errors++; $display("FAIL partial_wr got %h expected %h", wr_obs[0], wr_exp[0]); end
      void'(wr_obs.pop_front()); void'(wr_exp.pop_front());
    end
    b_obs.delete();
  endtask

  task automatic test_errors();
    int high, stable;
    bit ok;
    write_txn(8'h20, 32'hFFFF_FFFF, 4'hF, ok);
    b_exp.push_back(RESP_SLVERR);
    wait_b(0, high, ok);
    write_txn(8'h06, 32'hFFFF_FFFF, 4'hF, ok);
    b_exp.push_back(RESP_SLVERR);
    wait_b(0, high, ok);
    r_exp.push_back({32'h0, RESP_SLVERR});
    read_txn(8'h20, 0, stable, ok);
    checks++;
    if (wr_obs.size() != 0 || b_obs.size() != 2 || r_obs.size() != 1) begin
      errors++; $display("FAIL err_count got wr=%0d b=%0d r=%0d expected 0 2 1", wr_obs.size(), b_obs.size(), r_obs.size());
    end
    while (b_obs.size() && b_exp.size()) begin
      checks++;
      if (b_obs[0] !== b_exp[0]) begin errors++; $display("FAIL err_b got %b expected %b", b_obs[0], b_exp[0]); end
      void'(b_obs.pop_front()); void'(b_exp.pop_front());
    end
    while (r_obs.size() && r_exp.size()) begin
      checks++;
      if (r_obs[0] !== r_exp[0]) begin errors++; $display("FAIL err_r got %h expected %h", r_obs[0], r_exp[0]); end
      void'(r_obs.pop_front()); void'(r_exp.pop_front());
    end
    wr_obs.delete();
  endtask

  task automatic test_read_stall();
    int stable;
    bit ok;
    regs[3] = 32'h5A5A_0001;
    r_exp.push_back({32'h5A5A_0001, RESP_OKAY});
    read_txn(SRC_ADDR, 3, stable, ok);
    checks++;
    if (!ok || stable != 3) begin errors++; $display("FAIL rstall_hold got ok=%b stable_cycles=%0d expected 1 3", ok, stable); end
    checks++;
    if (r_obs.size() != r_exp.size()) begin errors++; $display("FAIL rstall_count got %0d expected %0d", r_obs.size(), r_exp.size()); end
    while (r_obs.size() && r_exp.size()) begin
      checks++;
      if (r_obs[0] !== r_exp[0]) begin errors++; $display("FAIL rstall_r got %h expected %h", r_obs[0], r_exp[0]); end
      void'(r_obs.pop_front()); void'(r_exp.pop_front());
    end
  endtask

  task automatic test_rd_during_wr();
    int high;
    bit ok;
    s_awaddr = STATUS; s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
    wr_exp.push_back({8'b0000_0010, 32'hDEAD_BEEF});
    r_exp.push_back({32'h0000_0003, RESP_OKAY});
    cyc();
    s_awvalid = 0; s_wvalid = 0;
    s_araddr = STATUS; s_arvalid = 1;
    checks++;
    if (reg_wr_en !== 8'b0000_0010 || s_arready !== 1'b1) begin
      errors++; $display("FAIL rdwr_exec got en=%b arready=%b expected 00000010 1", reg_wr_en, s_arready);
    end
    cyc();
    s_arvalid = 0;
    s_rready = 1;
    cyc();
    s_rready = 0;
    wait_b(0, high, ok);
    checks++;
    if (wr_obs.size() != wr_exp.size() || r_obs.size() != r_exp.size()) begin
      errors++; $display("FAIL rdwr_count got wr=%0d r=%0d expected 1 1", wr_obs.size(), r_obs.size());
    end
    while (wr_obs.size() && wr_exp.size()) begin
      checks++;
      if (wr_obs[0] !== wr_exp[0]) begin errors++; $display("FAIL rdwr_wr got %h expected %h", wr_obs[0], wr_exp[0]); end
      void'(wr_obs.pop_front()); void'(wr_exp.pop_front());
    end
    while (r_obs.size() && r_exp.size()) begin
      checks++;
      if (r_obs[0] !== r_exp[0]) begin errors++; $display("FAIL rdwr_r got %h expected %h", r_obs[0], r_exp[0]); end
      void'(r_obs.pop_front()); void'(r_exp.pop_front());
    end
    b_obs.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    s_bready = 0;
    wr_exp.push_back({8'b0001_0000, 32'h0000_0077});
    write_txn(DST_ADDR, 32'h0000_0077, 4'hF, ok);
    for (int n = 0; n < 10 && !s_bvalid; n++) cyc();
    checks++;
    if (s_bvalid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got bvalid=%b expected 1", s_bvalid); end
    #2 resetn = 0;
    #1;
    checks++;
    if (s_bvalid !== 1'b0 || s_awready !== 1'b0 || reg_wr_en !== 8'b0) begin
      errors++; $display("FAIL rstmid_async got bvalid=%b awready=%b en=%b expected 0 0 00000000", s_bvalid, s_awready, reg_wr_en);
    end
    s_bready = 1;
    cyc(); cyc();
    resetn = 1;
    for (int i = 0; i < 5; i++) cyc();
    s_bready = 0;
    checks++;
    if (wr_obs.size() != wr_exp.size() || b_obs.size() != 0) begin
      errors++; $display("FAIL rstmid_stray got wr=%0d b=%0d expected %0d 0", wr_obs.size(), b_obs.size(), wr_exp.size());
    end
    while (wr_obs.size() && wr_exp.size()) begin
      checks++;
      if (wr_obs[0] !== wr_exp[0]) begin errors++; $display("FAIL rstmid_wr got %h expected %h", wr_obs[0], wr_exp[0]); end
      void'(wr_obs.pop_front()); void'(wr_exp.pop_front());
    end
  endtask

  initial begin
    for (int k = 0; k < NREG; k++) regs[k] = 32'hC0DE_0000 | 32'(k);
    test_reset();
    test_basic();
    test_w_first();
    test_partial();
    test_errors();
    test_read_stall();
    test_rd_during_wr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
